// File: rtl/spdif_rx.sv
// Biphase-mark (S/PDIF / AES3) subframe receiver: measures pulse widths between
// line transitions, locks onto B/M/W preambles and emits one decoded subframe per strobe.
module spdif_rx #(
  parameter int UI_CLKS = 8,
  parameter int WIDTH   = 16
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        din,
  output logic [23:0] sample,
  output logic        v_bit,
  output logic        u_bit,
  output logic        c_bit,
  output logic        chan_b,
  output logic        blk_start,
  output logic        parity_err,
  output logic        sample_valid,
  output logic        locked,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {SEEK = 2'd0, PRE = 2'd1, DATA = 2'd2, PEND = 2'd3} state_t;
  typedef enum logic [1:0] {P_NONE = 2'd0, P_S = 2'd1, P_M = 2'd2, P_L = 2'd3} pulse_t;

  // Thresholds are compared against 2*w so half-UI boundaries stay integral.
  localparam logic [WIDTH:0]   LIM_G   = (WIDTH+1)'(UI_CLKS);
  localparam logic [WIDTH:0]   LIM_S   = (WIDTH+1)'(3 * UI_CLKS);
  localparam logic [WIDTH:0]   LIM_M   = (WIDTH+1)'(5 * UI_CLKS);
  localparam logic [WIDTH:0]   LIM_L   = (WIDTH+1)'(7 * UI_CLKS);
  localparam logic [WIDTH-1:0] TMO     = WIDTH'(8 * UI_CLKS);
  localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};

  state_t            state_q;
  logic              sync1_q, sync2_q, sync3_q;
  logic [WIDTH-1:0]  cnt_q, cnt_d;
  logic [1:0]        pre_idx_q;
  pulse_t            p0_q;
  logic              pre_b_q, pre_w_q;
  logic              half_q;
  logic [4:0]        bit_cnt_q;
  logic [27:0]       sr_q;
  logic [23:0]       sample_q;
  logic              v_q, u_q, c_q, chan_b_q, blk_q, perr_q, valid_q, locked_q;

  logic              edge_w;
  logic              timeout;
  logic [WIDTH:0]    w2;
  pulse_t            pcls;
  logic              pre_ok;
  logic              half_start, bit_one, bit_zero, bit_done;
  logic [27:0]       sr_shift;
  logic              fsm_err;

  assign edge_w  = sync2_q ^ sync3_q;
  assign w2      = {cnt_q, 1'b0};
  assign timeout = !edge_w && (cnt_q >= TMO);

  always_comb begin
    cnt_d = cnt_q;
    if (edge_w)               cnt_d = WIDTH'(1);
    else if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
  end

  always_comb begin
    pcls = P_NONE;
    if (w2 < LIM_G)      pcls = P_NONE;
    else if (w2 < LIM_S) pcls = P_S;
    else if (w2 < LIM_M) pcls = P_M;
    else if (w2 < LIM_L) pcls = P_L;
  end

  // Second preamble pulse is always S, so only the first and third discriminate.
  assign pre_ok = ((p0_q == P_S) && (pcls == P_L)) ||
                  ((p0_q == P_L) && (pcls == P_S)) ||
                  ((p0_q == P_M) && (pcls == P_M));

  assign half_start = (pcls == P_S) && !half_q;
  assign bit_one    = (pcls == P_S) &&  half_q;
  assign bit_zero   = (pcls == P_M) && !half_q;
  assign bit_done   = bit_one || bit_zero;
  assign sr_shift   = {half_q, sr_q[27:1]};

  always_comb begin
    fsm_err = 1'b0;
    if (state_q != SEEK) begin
      if (timeout) begin
        fsm_err = 1'b1;
      end else if (edge_w) begin
        case (state_q)
          PRE: begin
            case (pre_idx_q)
              2'd0:    fsm_err = (pcls == P_NONE);
              2'd1:    fsm_err = (pcls != P_S);
              default: fsm_err = !pre_ok;
            endcase
          end
          DATA:    fsm_err = !(half_start || bit_done);
          PEND:    fsm_err = (pcls != P_L);
          default: fsm_err = 1'b0;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q   <= SEEK;
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      sync3_q   <= 1'b0;
      cnt_q     <= '0;
      pre_idx_q <= 2'd0;
      p0_q      <= P_NONE;
      pre_b_q   <= 1'b0;
      pre_w_q   <= 1'b0;
      half_q    <= 1'b0;
      bit_cnt_q <= 5'd0;
      sr_q      <= '0;
      sample_q  <= '0;
      v_q       <= 1'b0;
      u_q       <= 1'b0;
      c_q       <= 1'b0;
      chan_b_q  <= 1'b0;
      blk_q     <= 1'b0;
      perr_q    <= 1'b0;
      valid_q   <= 1'b0;
      locked_q  <= 1'b0;
    end else begin
      sync1_q <= din;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
      cnt_q   <= cnt_d;
      valid_q <= 1'b0;
      if (fsm_err) begin
        state_q  <= SEEK;
        locked_q <= 1'b0;
      end else if (edge_w) begin
        case (state_q)
          SEEK: begin
            if (pcls == P_L) begin
              state_q   <= PRE;
              pre_idx_q <= 2'd0;
            end
          end
          PRE: begin
            case (pre_idx_q)
              2'd0: begin
                p0_q      <= pcls;
                pre_idx_q <= 2'd1;
              end
              2'd1:    pre_idx_q <= 2'd2;
              default: begin
                state_q   <= DATA;
                pre_b_q   <= (p0_q == P_S);
                pre_w_q   <= (p0_q == P_M);
                half_q    <= 1'b0;
                bit_cnt_q <= 5'd0;
                sr_q      <= '0;
              end
            endcase
          end
          DATA: begin
            if (half_start) begin
              half_q <= 1'b1;
            end else begin
              half_q <= 1'b0;
              sr_q   <= sr_shift;
              if (bit_cnt_q == 5'd27) begin
                sample_q <= sr_shift[23:0];
                v_q      <= sr_shift[24];
                u_q      <= sr_shift[25];
                c_q      <= sr_shift[26];
                perr_q   <= ^sr_shift;
                chan_b_q <= pre_w_q;
                blk_q    <= pre_b_q;
                valid_q  <= 1'b1;
                locked_q <= 1'b1;
                state_q  <= PEND;
              end else begin
                bit_cnt_q <= bit_cnt_q + 5'd1;
              end
            end
          end
          default: begin
            state_q   <= PRE;
            pre_idx_q <= 2'd0;
          end
        endcase
      end
    end
  end

  assign sample       = sample_q;
  assign v_bit        = v_q;
  assign u_bit        = u_q;
  assign c_bit        = c_q;
  assign chan_b       = chan_b_q;
  assign blk_start    = blk_q;
  assign parity_err   = perr_q;
  assign sample_valid = valid_q;
  assign locked       = locked_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_spdif_rx.sv
// Directed bench for spdif_rx: drives biphase-mark subframes and checks each strobe
// against hand-computed expected records.
module tb_spdif_rx;

  localparam int UI = 8;
  localparam int W  = 31;

  logic        clk  = 1'b0;
  logic        nrst = 1'b0;
  logic        din  = 1'b0;
  logic [23:0] sample;
  logic        v_bit, u_bit, c_bit, chan_b, blk_start, parity_err, sample_valid, locked;
  logic [1:0]  dbg_state;

  spdif_rx #(.UI_CLKS(UI), .WIDTH(16)) dut (
    .clk          (clk),
    .nrst         (nrst),
    .din          (din),
    .sample       (sample),
    .v_bit        (v_bit),
    .u_bit        (u_bit),
    .c_bit        (c_bit),
    .chan_b       (chan_b),
    .blk_start    (blk_start),
    .parity_err   (parity_err),
    .sample_valid (sample_valid),
    .locked       (locked),
    .dbg_state    (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] obs_q[$];
  bit jit    = 1'b0;
  bit jit_ph = 1'b0;
  logic [27:0] pl;

  always @(negedge clk)
    if (sample_valid)
      obs_q.push_back({sample, v_bit, u_bit, c_bit, chan_b, blk_start, parity_err, locked});

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input int w);
    repeat (w) @(negedge clk);
    din = ~din;
  endtask

  task automatic upulse(input int k);
    int u;
    if (jit) begin
      u = jit_ph ? 9 : 7;
      jit_ph = ~jit_ph;
    end else begin
      u = UI;
    end
    pulse(k * u);
  endtask

  task automatic lead_in();
    pulse(40);
  endtask

  // kind: 0 = B, 1 = M, 2 = W
  task automatic preamble(input int kind);
    case (kind)
      0:       begin upulse(3); upulse(1); upulse(1); upulse(3); end
      1:       begin upulse(3); upulse(3); upulse(1); upulse(1); end
      default: begin upulse(3); upulse(2); upulse(1); upulse(2); end
    endcase
  endtask

  task automatic bits(input logic [27:0] p, input int from, input int to);
    for (int i = from; i <= to; i++) begin
      if (p[i]) begin
        upulse(1);
        upulse(1);
      end else begin
        upulse(2);
      end
    end
  endtask

  task automatic subframe(input int kind, input logic [27:0] p);
    preamble(kind);
    bits(p, 0, 27);
  endtask

  function automatic logic [27:0] payload(input logic [23:0] s, input logic v, input logic u,
                                          input logic c, input logic flip);
    logic par;
    par = (^{c, u, v, s}) ^ flip;
    return {par, c, u, v, s};
  endfunction

  function automatic logic [W-1:0] rec(input logic [23:0] s, input logic v, input logic u,
                                       input logic c, input logic chb, input logic blk,
                                       input logic perr, input logic lk);
    return {s, v, u, c, chb, blk, perr, lk};
  endfunction

  // scoreboard
  task automatic score(input string tag);
    check({tag, "_count"}, obs_q.size(), exp_q.size());
    while (obs_q.size() > 0 && exp_q.size() > 0)
      check(tag, obs_q.pop_front(), exp_q.pop_front());
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    nrst = 1'b0;
    din  = 1'b0;
    clks(3);
    check("rst_sample", sample, 24'h0);
    check("rst_flags", {v_bit, u_bit, c_bit, chan_b, blk_start, parity_err, sample_valid, locked}, 8'h00);
    check("rst_state", dbg_state, 2'd0);
    nrst = 1'b1;
    clks(5);

    // B preamble, A5A5A5, C=1
    lead_in();
    exp_q.push_back(rec(24'hA5A5A5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1));
    subframe(0, payload(24'hA5A5A5, 1'b0, 1'b0, 1'b1, 1'b0));
    clks(6);
    check("state_pend", dbg_state, 2'd3);
    score("b_block");
    clks(80);
    check("hold_sample", sample, 24'hA5A5A5);
    check("hold_blk", blk_start, 1'b1);
    check("idle_unlock", locked, 1'b0);
    check("idle_seek", dbg_state, 2'd0);

    // M then W with inverted line polarity
    din = 1'b1;
    clks(80);
    lead_in();
    exp_q.push_back(rec(24'h000001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
    exp_q.push_back(rec(24'hFFFFFF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1));
    subframe(1, payload(24'h000001, 1'b0, 1'b0, 1'b0, 1'b0));
    subframe(2, payload(24'hFFFFFF, 1'b0, 1'b0, 1'b0, 1'b0));
    clks(6);
    score("m_w_inv");

    // flipped parity, then a good subframe
    clks(80);
    lead_in();
    exp_q.push_back(rec(24'h123456, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1));
    exp_q.push_back(rec(24'h654321, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
    subframe(0, payload(24'h123456, 1'b0, 1'b0, 1'b0, 1'b1));
    subframe(1, payload(24'h654321, 1'b0, 1'b1, 1'b0, 1'b0));
    clks(6);
    check("parity_locked", locked, 1'b1);
    score("parity");

    // line goes static mid-subframe
    clks(80);
    lead_in();
    exp_q.push_back(rec(24'h0BEEF0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
    subframe(1, payload(24'h0BEEF0, 1'b0, 1'b0, 1'b0, 1'b0));
    preamble(0);
    bits(payload(24'h222222, 1'b0, 1'b0, 1'b0, 1'b0), 0, 9);
    clks(80);
    check("static_unlock", locked, 1'b0);
    check("static_seek", dbg_state, 2'd0);
    score("static");
    lead_in();
    exp_q.push_back(rec(24'hABCDEF, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1));
    subframe(2, payload(24'hABCDEF, 1'b1, 1'b0, 1'b0, 1'b0));
    clks(6);
    score("recover");

    // 3-clk glitch inside data
    clks(80);
    lead_in();
    exp_q.push_back(rec(24'h111111, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
    subframe(1, payload(24'h111111, 1'b0, 1'b0, 1'b0, 1'b0));
    pl = payload(24'h444444, 1'b0, 1'b0, 1'b0, 1'b0);
    preamble(0);
    bits(pl, 0, 4);
    pulse(3);
    bits(pl, 5, 27);
    clks(6);
    check("glitch_unlock", locked, 1'b0);
    check("glitch_seek", dbg_state, 2'd0);
    score("glitch");

    // +/-12% jitter (7 and 9 clks per UI)
    clks(80);
    jit = 1'b1;
    lead_in();
    exp_q.push_back(rec(24'h5A5A5A, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1));
    exp_q.push_back(rec(24'hC3C3C3, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1));
    subframe(1, payload(24'h5A5A5A, 1'b0, 1'b0, 1'b1, 1'b0));
    subframe(2, payload(24'hC3C3C3, 1'b1, 1'b1, 1'b0, 1'b0));
    jit = 1'b0;
    clks(6);
    score("jitter");

    // asynchronous reset mid-subframe
    clks(80);
    lead_in();
    exp_q.push_back(rec(24'h777777, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1));
    subframe(2, payload(24'h777777, 1'b0, 1'b0, 1'b0, 1'b0));
    pl = payload(24'h333333, 1'b0, 1'b0, 1'b0, 1'b0);
    preamble(0);
    bits(pl, 0, 11);
    #3 nrst = 1'b0;
    #1;
    check("arst_sample", sample, 24'h0);
    check("arst_flags", {v_bit, u_bit, c_bit, chan_b, blk_start, parity_err, sample_valid, locked}, 8'h00);
    check("arst_state", dbg_state, 2'd0);
    clks(2);
    nrst = 1'b1;
    bits(pl, 12, 27);
    exp_q.push_back(rec(24'h0F0F0F, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1));
    subframe(0, payload(24'h0F0F0F, 1'b0, 1'b0, 1'b0, 1'b0));
    clks(6);
    score("arst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spdif_rx.md
SPDIF_RX -- requirements
Module: spdif_rx

Interface
REQ-001 SHALL have parameter UI_CLKS, default 8: clk cycles per unit interval (half bit cell); minimum 4.
REQ-002 SHALL have parameter WIDTH, default 16: pulse-width counter width; 2**WIDTH-1 >= 8*UI_CLKS.
REQ-003 clk  input  1  system clock; all logic on rising edge.
REQ-004 nrst  input  1  reset, asynchronous, active-low.
REQ-005 din  input  1  biphase-mark (S/PDIF/AES3) serial line, asynchronous to clk.
REQ-006 sample  output  24  audio word, time slots 4..27, slot 4 at bit 0.
REQ-007 v_bit, u_bit, c_bit  output  1 each  validity, user and channel-status bits, slots 28..30.
REQ-008 chan_b  output  1  0 = subframe A (B or M preamble), 1 = subframe B (W preamble).
REQ-009 blk_start  output  1  subframe was opened by a B preamble.
REQ-010 parity_err  output  1  even parity over slots 4..31 failed.
REQ-011 sample_valid  output  1  one-cycle strobe qualifying all of the above.
REQ-012 locked  output  1  at least one complete subframe decoded since the last error.

Function
REQ-013 SHALL synchronise din through two flops, then detect any transition with a third flop; every transition ends one pulse.
REQ-014 SHALL count clk cycles between detected transitions as width w, saturating at 2**WIDTH-1, and restart at 1 on each transition.
REQ-015 SHALL classify w, with N = UI_CLKS:
- 2w < N: glitch (error)
- 2w < 3N: short (S)
- 2w < 5N: medium (M)
- 2w < 7N: long (L)
- otherwise: error
REQ-016 SHALL treat w reaching 8N without a transition as a timeout error.
REQ-017 SHALL implement states SEEK, PRE, DATA, PEND.
- SEEK: an L pulse -> PRE; all other pulses are ignored.
- PRE: the three pulses following the L select the preamble; anything else is an error.
  - S,S,L = B
  - L,S,S = M
  - M,S,M = W
- DATA: decode 28 bits.
- PEND: expect an L pulse.
REQ-018 SHALL decode bits in DATA as follows.
- M pulse = 0.
- S then S = 1.
- S then non-S, or an L pulse = error.
REQ-019 SHALL shift decoded bits LSB-first into slots 4..31.
REQ-020 SHALL, on the pulse completing slot 31, register all outputs and assert sample_valid for exactly one cycle, one clk after the transition that ended slot 31 is detected, then enter PEND.
REQ-021 SHALL, in PEND, go to PRE when the pulse is L; any other pulse is an error.
REQ-022 SHALL set parity_err = XOR of slots 4..31; sample_valid is still asserted when parity_err = 1.
REQ-023 SHALL, on any error (glitch, out-of-range width, timeout, bad preamble, bad bit), go to SEEK, deassert locked the next cycle, and discard the partial subframe without asserting sample_valid.
REQ-024 SHALL assert locked with the first sample_valid after SEEK and hold it until the next error.
REQ-025 SHALL decode identically for either line polarity; only pulse widths are used.
REQ-026 SHALL hold sample, v_bit, u_bit, c_bit, chan_b, blk_start and parity_err stable between sample_valid strobes.

Reset
REQ-027 SHALL, while nrst = 0, asynchronously force:
- state SEEK
- counters and shift register to 0
- all outputs to 0
- synchroniser flops to 0
REQ-028 SHALL, after reset deasserts mid-subframe, resynchronise only at the next L pulse; no sample_valid until a full subframe completes.

Verification (UI_CLKS = 8)
REQ-029 B preamble, sample 24'hA5A5A5, V=0 U=0 C=1, correct parity -> one sample_valid with sample = 24'hA5A5A5, c_bit = 1, chan_b = 0, blk_start = 1, parity_err = 0, locked = 1.
REQ-030 Frame of M then W subframes carrying 24'h000001 and 24'hFFFFFF, driven with inverted line polarity -> two strobes with sample values as sent; chan_b = 0 then 1; blk_start = 0 both times.
REQ-031 Subframe with the parity bit flipped -> sample_valid with parity_err = 1; the following good subframe gives parity_err = 0 and locked stays 1.
REQ-032 Line held static for 64 clks mid-subframe -> no sample_valid, locked = 0, state SEEK; the next full subframe decodes correctly.
REQ-033 3-clk glitch pulse inside data, or pulse widths stretched ±12% (w = 7 and 9 per UI) -> glitch causes an error and no strobe; ±12% jitter decodes without error.
REQ-034 nrst pulsed low mid-subframe -> all outputs 0 immediately and asynchronously; the partial subframe yields no strobe; the first complete subframe after the next preamble strobes correctly.
